// File: rtl/vid_isa_regs.sv
// ISA-bus front end for the CGA/Tandy video adapter: bus decode, mode/colour
// registers, Tandy palette, optional memory wait states and blink timebase.
module vid_isa_regs #(
   parameter logic [15:0] IO_BASE_ADDR       = 16'h3D0,
   parameter int          ADDR_W             = 15,
   parameter int          PAL_ENTRIES        = 16,
   parameter bit          USE_BUS_WAIT       = 1'b0,
   parameter int          WAIT_CYCLES        = 3,
   parameter logic [23:0] BLINK_MAX          = 24'd7_499_999,
   parameter logic [7:0]  CTRL_RESET         = 8'h29,
   parameter bit          NO_DISPLAY_DISABLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] bus_a,
   input  logic [7:0]        bus_d,
   input  logic              bus_ior_l,
   input  logic              bus_iow_l,
   input  logic              bus_memr_l,
   input  logic              bus_memw_l,
   input  logic              bus_mem_cs,
   input  logic              bus_aen,
   output logic [7:0]        bus_out,
   output logic              bus_dir,
   output logic              bus_rdy,
   output logic              crtc_cs,
   output logic              crtc_wr,
   output logic              crtc_rd,
   input  logic [7:0]        crtc_bus_out,
   input  logic              crtc_vsync,
   input  logic              display_enable,
   output logic [7:0]        control_reg,
   output logic [7:0]        color_reg,
   output logic              hres_mode,
   output logic              grph_mode,
   output logic              bw_mode,
   output logic              mode_640,
   output logic              blink_enabled,
   output logic              video_enabled,
   input  logic [3:0]        pal_idx,
   output logic [3:0]        pal_color,
   input  logic              blink_hold,
   output logic              blink_fast,
   output logic              blink_slow
);

   localparam logic [ADDR_W-1:0] BASE     = IO_BASE_ADDR[ADDR_W-1:0];
   localparam logic [3:0]        PAL_MASK = 4'(PAL_ENTRIES - 1);

   // ---------------------------------------------------------------- sync
   logic [1:0] ior_sync, iow_sync;
   logic       iow_prev;
   logic       ior_s, iow_s, wr_pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ior_sync <= 2'b11;
         iow_sync <= 2'b11;
         iow_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking so each stage samples the previous stage's old value.
         ior_sync <= {ior_sync[0], bus_ior_l};
         iow_sync <= {iow_sync[0], bus_iow_l};
         iow_prev <= iow_sync[1];
      end
   end

   assign ior_s    = ior_sync[1];
   assign iow_s    = iow_sync[1];
   assign wr_pulse = iow_prev & ~iow_s;

   // -------------------------------------------------------------- decode
   logic       win_hit, crtc_hit, ctrl_hit, color_hit, status_hit, ga_data_hit;
   logic [3:0] offset;

   assign offset      = bus_a[3:0];
   assign win_hit     = ~bus_aen & (bus_a[ADDR_W-1:4] == BASE[ADDR_W-1:4]);
   assign crtc_hit    = win_hit & ~offset[3];
   assign ctrl_hit    = win_hit & (offset == 4'h8);
   assign color_hit   = win_hit & (offset == 4'h9);
   assign status_hit  = win_hit & (offset == 4'hA);
   assign ga_data_hit = win_hit & (offset == 4'hE);

   assign crtc_cs = crtc_hit;
   assign crtc_wr = ~iow_s;
   assign crtc_rd = ~ior_s;

   // ----------------------------------------------------------- registers
   logic [7:0] ga_index;
   logic [3:0] palette [16];
   logic       pal_we;
   logic [3:0] pal_wr_idx;

   assign pal_we     = wr_pulse & ga_data_hit & (ga_index[7:4] == 4'h1);
   assign pal_wr_idx = ga_index[3:0] & PAL_MASK;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         control_reg <= CTRL_RESET;
         color_reg   <= '0;
         ga_index    <= '0;
         pal_color   <= '0;
         // NOTE: palette needs a known identity map at reset, so it is built from
         // flops rather than a RAM macro; only 16 x 4 bits, so this is cheap.
         for (int i = 0; i < 16; i++) palette[i] <= 4'(i);
      end else begin
         if (wr_pulse && ctrl_hit)   control_reg <= bus_d;
         if (wr_pulse && color_hit)  color_reg   <= bus_d;
         if (wr_pulse && status_hit) ga_index    <= bus_d;
         if (pal_we)                 palette[pal_wr_idx] <= bus_d[3:0];
         pal_color <= palette[pal_idx & PAL_MASK];
      end
   end

   assign hres_mode     = control_reg[0];
   assign grph_mode     = control_reg[1];
   assign bw_mode       = control_reg[2];
   assign mode_640      = control_reg[4];
   assign blink_enabled = control_reg[5];
   assign video_enabled = NO_DISPLAY_DISABLE ? 1'b1 : control_reg[3];

   // --------------------------------------------------------------- reads
   logic [7:0] rd_data;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd_data = 8'h00;
      if (status_hit)
         rd_data = {4'b1111, crtc_vsync, 2'b10, ~display_enable};
      else if (crtc_hit && offset[0])
         rd_data = crtc_bus_out;
   end

   assign bus_out = ~ior_s ? rd_data : 8'h00;
   assign bus_dir = (crtc_hit | status_hit) & ~bus_ior_l;

   // ---------------------------------------------------------- wait state
   generate
      if (USE_BUS_WAIT) begin : g_wait
         typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} wait_state_t;

         wait_state_t state, state_next;
         logic [3:0]  cnt, cnt_next;
         logic [1:0]  memr_sync, memw_sync;
         logic        mem_req;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               memr_sync <= 2'b11;
               memw_sync <= 2'b11;
               state     <= ST_IDLE;
               cnt       <= '0;
            end else begin
               memr_sync <= {memr_sync[0], bus_memr_l};
               memw_sync <= {memw_sync[0], bus_memw_l};
               state     <= state_next;
               cnt       <= cnt_next;
            end
         end

         assign mem_req = ~memr_sync[1] | ~memw_sync[1];

         always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
               ST_IDLE: if (mem_req && bus_mem_cs) begin
                  state_next = ST_WAIT;
                  cnt_next   = '0;
               end
               ST_WAIT: begin
                  // A strobe released early abandons the access immediately.
                  if (!mem_req)                          state_next = ST_IDLE;
                  else if (cnt == 4'(WAIT_CYCLES - 1))   state_next = ST_DONE;
                  else                                   cnt_next   = cnt + 4'd1;
               end
               ST_DONE: if (!mem_req) state_next = ST_IDLE;
               default: state_next = ST_IDLE;
            endcase
         end

         assign bus_rdy = (state != ST_WAIT);
      end else begin : g_no_wait
         logic unused_mem;
         assign unused_mem = &{1'b0, bus_memr_l, bus_memw_l, bus_mem_cs};
         assign bus_rdy    = 1'b1;
      end
   endgenerate

   // --------------------------------------------------------------- blink
   logic [23:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt  <= '0;
         blink_fast <= 1'b0;
         blink_slow <= 1'b0;
      end else if (!blink_hold) begin
         if (blink_cnt == BLINK_MAX) begin
            blink_cnt  <= '0;
            blink_fast <= ~blink_fast;
            if (!blink_fast) blink_slow <= ~blink_slow;
         end else begin
            blink_cnt <= blink_cnt + 24'd1;
         end
      end
   end

endmodule

// File: tb/tb_vid_isa_regs.sv
// Directed bench for vid_isa_regs: register writes, status/CRTC reads,
// palette, memory wait states and blink timebase.
module tb_vid_isa_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
   logic        bus_mem_cs, bus_aen;
   logic [7:0]  bus_out;
   logic        bus_dir, bus_rdy, crtc_cs, crtc_wr, crtc_rd;
   logic [7:0]  crtc_bus_out;
   logic        crtc_vsync, display_enable;
   logic [7:0]  control_reg, color_reg;
   logic        hres_mode, grph_mode, bw_mode, mode_640, blink_enabled, video_enabled;
   logic [3:0]  pal_idx, pal_color;
   logic        blink_hold, blink_fast, blink_slow;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   vid_isa_regs #(
      .USE_BUS_WAIT(1'b1),
      .WAIT_CYCLES (3),
      .BLINK_MAX   (24'd3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus_a         (bus_a),
      .bus_d         (bus_d),
      .bus_ior_l     (bus_ior_l),
      .bus_iow_l     (bus_iow_l),
      .bus_memr_l    (bus_memr_l),
      .bus_memw_l    (bus_memw_l),
      .bus_mem_cs    (bus_mem_cs),
      .bus_aen       (bus_aen),
      .bus_out       (bus_out),
      .bus_dir       (bus_dir),
      .bus_rdy       (bus_rdy),
      .crtc_cs       (crtc_cs),
      .crtc_wr       (crtc_wr),
      .crtc_rd       (crtc_rd),
      .crtc_bus_out  (crtc_bus_out),
      .crtc_vsync    (crtc_vsync),
      .display_enable(display_enable),
      .control_reg   (control_reg),
      .color_reg     (color_reg),
      .hres_mode     (hres_mode),
      .grph_mode     (grph_mode),
      .bw_mode       (bw_mode),
      .mode_640      (mode_640),
      .blink_enabled (blink_enabled),
      .video_enabled (video_enabled),
      .pal_idx       (pal_idx),
      .pal_color     (pal_color),
      .blink_hold    (blink_hold),
      .blink_fast    (blink_fast),
      .blink_slow    (blink_slow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dut.wr_pulse) pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [14:0] addr, input logic [7:0] data, input int hold = 4);
      bus_a     = addr;
      bus_d     = data;
      bus_iow_l = 1'b0;
      tick(hold);
      bus_iow_l = 1'b1;
      tick(4);
   endtask

   initial begin
      int low;
      rst_n = 1'b0; bus_a = '0; bus_d = '0;
      bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
      bus_mem_cs = 1'b0; bus_aen = 1'b0; crtc_bus_out = '0;
      crtc_vsync = 1'b0; display_enable = 1'b1; pal_idx = 4'd5; blink_hold = 1'b1;
      tick(3);
      check("rst_pal_color", pal_color, 4'h0);
      rst_n = 1'b1;
      check("rst_control", control_reg, 8'h29);
      check("rst_hres", hres_mode, 1'b1);
      check("rst_grph", grph_mode, 1'b0);
      check("rst_color", color_reg, 8'h00);
      check("rst_rdy", bus_rdy, 1'b1);
      check("video_en", video_enabled, 1'b1);
      tick();
      check("pal_reset_5", pal_color, 4'h5);

      // Long write strobe must commit once.
      pulses = 0;
      io_write(15'h3D8, 8'h1A, 20);
      check("ctrl_write", control_reg, 8'h1A);
      check("ctrl_grph", grph_mode, 1'b1);
      check("ctrl_640", mode_640, 1'b1);
      check("ctrl_hres", hres_mode, 1'b0);
      check("one_pulse", pulses, 1);

      bus_aen = 1'b1;
      io_write(15'h3D8, 8'h55);
      bus_aen = 1'b0;
      check("aen_block", control_reg, 8'h1A);

      io_write(15'h3D9, 8'h3C);
      check("color_write", color_reg, 8'h3C);

      // Palette via gate-array index/data.
      io_write(15'h3DA, 8'h13);
      io_write(15'h3DE, 8'h0C);
      pal_idx = 4'd3; tick();
      check("pal3_write", pal_color, 4'hC);
      io_write(15'h3DA, 8'h02);
      io_write(15'h3DE, 8'h07);
      pal_idx = 4'd2; tick();
      check("pal2_kept", pal_color, 4'h2);
      pal_idx = 4'd3; tick();
      check("pal3_kept", pal_color, 4'hC);
      pal_idx = 4'd7; tick();
      check("pal7_reset", pal_color, 4'h7);

      // Reads.
      crtc_vsync = 1'b1; display_enable = 1'b0; crtc_bus_out = 8'h4E;
      bus_a = 15'h3DA; bus_ior_l = 1'b0;
      #1;
      check("status_dir", bus_dir, 1'b1);
      tick(3);
      check("status_read", bus_out, 8'hFD);
      check("crtc_rd", crtc_rd, 1'b1);
      bus_a = 15'h3D5; #1;
      check("crtc_read", bus_out, 8'h4E);
      check("crtc_cs", crtc_cs, 1'b1);
      check("crtc_dir", bus_dir, 1'b1);
      bus_a = 15'h3D9; #1;
      check("color_read", bus_out, 8'h00);
      check("color_dir", bus_dir, 1'b0);
      check("color_cs", crtc_cs, 1'b0);
      bus_ior_l = 1'b1;
      tick(3);
      check("crtc_rd_idle", crtc_rd, 1'b0);

      // Memory wait states.
      bus_mem_cs = 1'b1; bus_memr_l = 1'b0;
      tick(2);
      check("rdy_sync", bus_rdy, 1'b1);
      low = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!bus_rdy) low++;
         else if (low > 0) break;
      end
      check("wait_len", low, 3);
      tick(3);
      check("rdy_done_hold", bus_rdy, 1'b1);
      bus_memr_l = 1'b1;
      tick(4);
      check("rdy_idle", bus_rdy, 1'b1);

      // Reset in the middle of an access.
      bus_memr_l = 1'b0;
      tick(3);
      check("rdy_in_wait", bus_rdy, 1'b0);
      rst_n = 1'b0; bus_memr_l = 1'b1;
      tick();
      check("rdy_reset_abort", bus_rdy, 1'b1);
      check("ctrl_reset_again", control_reg, 8'h29);
      rst_n = 1'b1; bus_mem_cs = 1'b0;
      tick(2);

      // Blink: counter held at 0 since reset, release and count edges.
      blink_hold = 1'b0;
      tick(3);
      check("fast_n3", blink_fast, 1'b0);
      tick();
      check("fast_n4", blink_fast, 1'b1);
      check("slow_n4", blink_slow, 1'b1);
      tick(4);
      check("fast_n8", blink_fast, 1'b0);
      check("slow_n8", blink_slow, 1'b1);
      tick(4);
      check("fast_n12", blink_fast, 1'b1);
      check("slow_n12", blink_slow, 1'b0);
      tick(2);
      blink_hold = 1'b1;
      tick(10);
      check("hold_fast", blink_fast, 1'b1);
      check("hold_slow", blink_slow, 1'b0);
      blink_hold = 1'b0;
      tick();
      check("resume_n15", blink_fast, 1'b1);
      tick();
      check("resume_n16", blink_fast, 1'b0);
      check("resume_slow", blink_slow, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
